// File: rtl/alias_reduction_if.sv
// Control, coefficient-ROM and sample-RAM signals of the alias-reduction stage.
// The master modport is the datapath side, the slave modport is its environment.
interface alias_reduction_if #(
  parameter int DATA_WIDTH = 24
);
  logic                         start;
  logic [1:0]                   block_type;
  logic                         mixed_block;
  logic                         busy;
  logic                         done;
  logic                         coef_en;
  logic [2:0]                   coef_index;
  logic signed [17:0]           cs_data;
  logic signed [17:0]           ca_data;
  logic [9:0]                   mem_raddr;
  logic signed [DATA_WIDTH-1:0] mem_rdata;
  logic [9:0]                   mem_waddr;
  logic signed [DATA_WIDTH-1:0] mem_wdata;
  logic                         mem_we;

  modport master (
    input  start, block_type, mixed_block, cs_data, ca_data, mem_rdata,
    output busy, done, coef_en, coef_index, mem_raddr, mem_waddr, mem_wdata, mem_we
  );

  modport slave (
    output start, block_type, mixed_block, cs_data, ca_data, mem_rdata,
    input  busy, done, coef_en, coef_index, mem_raddr, mem_waddr, mem_wdata, mem_we
  );
endinterface

// File: rtl/alias_reduction.sv
// MP3 alias-reduction butterflies applied in place across the subband boundaries of a
// 576-line sample RAM; one read/read/multiply/write/write sequence per butterfly.
module alias_reduction #(
  parameter int DATA_WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  alias_reduction_if.master bus
);
  // state | meaning:  IDLE wait for start | RD_LO lo addr + coef read | RD_HI capture lo/cs/ca, hi addr
  //   MUL capture hi, register results | WR_LO/WR_HI write back, advance | DONE one-cycle pulse
  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_MUL, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  localparam int PW = DATA_WIDTH + 18;
  localparam int SW = DATA_WIDTH + 19;
  localparam logic signed [SW-1:0] RND     = SW'(65536);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [1:0]                   block_type_q, block_type_d;
  logic                         mixed_q, mixed_d;
  logic [4:0]                   sb_q, sb_d;
  logic [2:0]                   i_q, i_d;
  logic signed [DATA_WIDTH-1:0] lo_q, lo_d;
  logic signed [17:0]           cs_q, cs_d;
  logic signed [17:0]           ca_q, ca_d;
  logic signed [DATA_WIDTH-1:0] lo_res_q, lo_res_d;
  logic signed [DATA_WIDTH-1:0] hi_res_q, hi_res_d;

  logic                         skip_start;
  logic                         last_bfly;
  logic [9:0]                   base_addr, lo_addr, hi_addr;
  logic signed [DATA_WIDTH-1:0] hi_w;
  logic signed [SW-1:0]         sum_lo, sum_hi;
  logic signed [DATA_WIDTH-1:0] lo_sat, hi_sat;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (x < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return x[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    skip_start = (bus.block_type == 2'd2) && !bus.mixed_block;
    last_bfly  = (i_q == 3'd7) &&
                 (sb_q == (((block_type_q == 2'd2) && mixed_q) ? 5'd1 : 5'd31));
    base_addr  = 10'(sb_q) * 10'd18;
    lo_addr    = base_addr - 10'd1 - 10'(i_q);
    hi_addr    = base_addr + 10'(i_q);
  end

  // hi is consumed straight off the RAM read port during MUL
  always_comb begin
    hi_w   = bus.mem_rdata;
    sum_lo = SW'(PW'(lo_q) * PW'(cs_q)) - SW'(PW'(hi_w) * PW'(ca_q)) + RND;
    sum_hi = SW'(PW'(hi_w) * PW'(cs_q)) + SW'(PW'(lo_q) * PW'(ca_q)) + RND;
    lo_sat = sat(sum_lo >>> 17);
    hi_sat = sat(sum_hi >>> 17);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = skip_start ? S_DONE : S_RD_LO;
      S_RD_LO: state_d = S_RD_HI;
      S_RD_HI: state_d = S_MUL;
      S_MUL:   state_d = S_WR_LO;
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: state_d = last_bfly ? S_DONE : S_RD_LO;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_DONE);
    bus.coef_en    = (state_q == S_RD_LO);
    bus.coef_index = (state_q == S_RD_LO) ? i_q : 3'd0;
    bus.mem_raddr  = (state_q == S_RD_LO) ? lo_addr :
                     (state_q == S_RD_HI) ? hi_addr : 10'd0;
    bus.mem_we     = (state_q == S_WR_LO) || (state_q == S_WR_HI);
    bus.mem_waddr  = (state_q == S_WR_LO) ? lo_addr :
                     (state_q == S_WR_HI) ? hi_addr : 10'd0;
    bus.mem_wdata  = (state_q == S_WR_LO) ? lo_res_q :
                     (state_q == S_WR_HI) ? hi_res_q : '0;
  end

  always_comb begin
    block_type_d = block_type_q;
    mixed_d      = mixed_q;
    sb_d         = sb_q;
    i_d          = i_q;
    lo_d         = lo_q;
    cs_d         = cs_q;
    ca_d         = ca_q;
    lo_res_d     = lo_res_q;
    hi_res_d     = hi_res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          block_type_d = bus.block_type;
          mixed_d      = bus.mixed_block;
          sb_d         = 5'd1;
          i_d          = 3'd0;
        end
      end
      S_RD_HI: begin
        lo_d = bus.mem_rdata;
        cs_d = bus.cs_data;
        ca_d = bus.ca_data;
      end
      S_MUL: begin
        lo_res_d = lo_sat;
        hi_res_d = hi_sat;
      end
      S_WR_HI: begin
        if (!last_bfly) begin
          if (i_q == 3'd7) begin
            i_d  = 3'd0;
            sb_d = sb_q + 5'd1;
          end else begin
            i_d = i_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      block_type_q <= 2'd0;
      mixed_q      <= 1'b0;
      sb_q         <= 5'd0;
      i_q          <= 3'd0;
      lo_q         <= '0;
      cs_q         <= '0;
      ca_q         <= '0;
      lo_res_q     <= '0;
      hi_res_q     <= '0;
    end else begin
      block_type_q <= block_type_d;
      mixed_q      <= mixed_d;
      sb_q         <= sb_d;
      i_q          <= i_d;
      lo_q         <= lo_d;
      cs_q         <= cs_d;
      ca_q         <= ca_d;
      lo_res_q     <= lo_res_d;
      hi_res_q     <= hi_res_d;
    end
  end
endmodule

// File: tb/tb_alias_reduction.sv
// Directed bench for alias_reduction: sample-RAM and ROM models, a write-stream
// scoreboard fed by a butterfly model, and cycle-exact timing checks per pass.
module tb_alias_reduction;
  localparam int     DW   = 24;
  localparam int     N    = 576;
  localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (DW - 1));

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alias_reduction_if #(.DATA_WIDTH(DW)) bus ();
  alias_reduction #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  logic signed [DW-1:0] ram [N];
  longint               stage [N];
  longint               mdl [N];
  longint               rom_cs [8];
  longint               rom_ca [8];
  logic                 load_req;
  logic [DW+9:0]        exp_q [$];
  int                   n_cmp = 0;
  int                   n_fail = 0;

  // RAM and ROMs with one-cycle read latency
  always @(posedge clk) begin
    bus.mem_rdata <= (int'(bus.mem_raddr) < N) ? ram[int'(bus.mem_raddr)] : '0;
    if (bus.coef_en) begin
      bus.cs_data <= 18'(rom_cs[bus.coef_index]);
      bus.ca_data <= 18'(rom_ca[bus.coef_index]);
    end
    if (load_req) begin
      for (int a = 0; a < N; a++) ram[a] <= DW'(stage[a]);
    end else if (bus.mem_we && int'(bus.mem_waddr) < N) begin
      ram[int'(bus.mem_waddr)] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      $error("%s", tag);
    end
  endtask

  function automatic longint bf(input longint s);
    longint r;
    r = (s + 65536) >>> 17;
    if (r > SMAX) return SMAX;
    if (r < SMIN) return SMIN;
    return r;
  endfunction

  task automatic rom_real();
    rom_cs = '{112393, 115571, 124470, 128885, 130485, 130962, 131059, 131071};
    rom_ca = '{-67436, -61830, -41075, -23844, -12396, -5369, -1861, -485};
  endtask

  task automatic rom_stub();
    for (int i = 0; i < 8; i++) begin
      rom_cs[i] = 131071;
      rom_ca[i] = -131072;
    end
  endtask

  task automatic clear_stage();
    for (int a = 0; a < N; a++) stage[a] = 0;
  endtask

  task automatic fill_random();
    logic signed [DW-1:0] t;
    for (int a = 0; a < N; a++) begin
      t = DW'($urandom);
      stage[a] = longint'(t);
    end
  endtask

  task automatic load_stage();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic build_expected(input logic [1:0] bt, input logic mb);
    int     nsb, lo, hi;
    longint lo_v, hi_v, nlo, nhi;
    exp_q.delete();
    for (int a = 0; a < N; a++) mdl[a] = stage[a];
    nsb = (bt == 2'd2) ? (mb ? 1 : 0) : 31;
    for (int sb = 1; sb <= nsb; sb++) begin
      for (int i = 0; i < 8; i++) begin
        lo   = 18 * sb - 1 - i;
        hi   = 18 * sb + i;
        lo_v = mdl[lo];
        hi_v = mdl[hi];
        nlo  = bf(lo_v * rom_cs[i] - hi_v * rom_ca[i]);
        nhi  = bf(hi_v * rom_cs[i] + lo_v * rom_ca[i]);
        mdl[lo] = nlo;
        mdl[hi] = nhi;
        exp_q.push_back({10'(lo), DW'(nlo)});
        exp_q.push_back({10'(hi), DW'(nhi)});
      end
    end
  endtask

  // One pass: start sampled at edge T, cycle n is sampled at the negedge after edge T+n.
  task automatic run_pass(input string nm, input logic [1:0] bt, input logic mb,
                          input int exp_done, input int exp_wr, input int abort_at,
                          input int ms1, input int ms2, input int exp_wmin, input int exp_wmax);
    int            n, done_at, dones, wr, busy_c, coef_c, wmin, wmax;
    logic [DW+9:0] e;
    build_expected(bt, mb);
    done_at = -1; dones = 0; wr = 0; busy_c = 0; coef_c = 0; wmin = N; wmax = -1;
    bus.block_type  = bt;
    bus.mixed_block = mb;
    bus.start       = 1'b1;
    n = 1;
    @(negedge clk);
    while (n <= 1400) begin
      if (bus.mem_we) begin
        wr++;
        if (int'(bus.mem_waddr) < wmin) wmin = int'(bus.mem_waddr);
        if (int'(bus.mem_waddr) > wmax) wmax = int'(bus.mem_waddr);
        if (exp_q.size() == 0) check({nm, "_extra_write"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          check({nm, "_write"}, {bus.mem_waddr, bus.mem_wdata}, e);
        end
      end
      if (bus.coef_en) coef_c++;
      if (bus.busy) busy_c++;
      if (bus.done) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
      if (abort_at > 0 && n == abort_at)
        check({nm, "_rst_outputs"}, {bus.busy, bus.done, bus.coef_en, bus.mem_we, bus.coef_index,
                                     bus.mem_raddr, bus.mem_waddr, bus.mem_wdata}, 0);
      bus.start = (n == ms1) || (n == ms2);
      if (abort_at > 0 && n == abort_at - 1) rst_n = 1'b0;
      if (abort_at > 0 && n == abort_at + 1) rst_n = 1'b1;
      if ((done_at > 0 && n >= done_at + 3) || (abort_at > 0 && n >= abort_at + 6)) break;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    check({nm, "_done_cycle"}, done_at, exp_done);
    check({nm, "_done_count"}, dones, (abort_at > 0) ? 0 : 1);
    check({nm, "_writes"}, wr, exp_wr);
    check({nm, "_coef_reads"}, coef_c, (abort_at > 0) ? (abort_at + 3) / 5 : exp_wr / 2);
    check({nm, "_busy_cycles"}, busy_c, (abort_at > 0) ? abort_at - 1 : exp_done);
    check({nm, "_wmin"}, wmin, exp_wmin);
    check({nm, "_wmax"}, wmax, exp_wmax);
    if (abort_at == 0) check({nm, "_left_in_queue"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_image(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a < N; a++) if (ram[a] !== DW'(mdl[a])) bad++;
    check(nm, bad, 0);
  endtask

  function automatic int nonzero_except(input int a0, input int a1);
    int cnt;
    cnt = 0;
    for (int a = 0; a < N; a++) if (a != a0 && a != a1 && ram[a] !== '0) cnt++;
    return cnt;
  endfunction

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.block_type  = 2'd0;
    bus.mixed_block = 1'b0;
    load_req        = 1'b0;
    rom_real();
    clear_stage();
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.coef_en, bus.mem_we, bus.coef_index,
                            bus.mem_raddr, bus.mem_waddr, bus.mem_wdata}, 0);
    rst_n = 1'b1;
    load_stage();

    run_pass("zero", 2'd0, 1'b0, 1241, 496, 0, 0, 0, 10, 565);
    check("zero_nonzero_words", nonzero_except(-1, -1), 0);

    clear_stage();
    stage[17] = 100000;
    load_stage();
    run_pass("single", 2'd1, 1'b0, 1241, 496, 0, 0, 0, 10, 565);
    check("single_x17", ram[17], 85749);
    check("single_x18", ram[18], -51450);
    check("single_others_zero", nonzero_except(17, 18), 0);

    rom_stub();
    clear_stage();
    stage[17] = 8388607;
    stage[18] = 8388607;
    load_stage();
    run_pass("sat_mixed", 2'd2, 1'b1, 41, 16, 0, 20, 41, 10, 25);
    check("sat_x17", ram[17], 8388607);
    check("sat_x18", ram[18], -64);
    check_image("sat_image");

    rom_real();
    fill_random();
    load_stage();
    run_pass("skip", 2'd2, 1'b0, 1, 0, 0, 0, 0, N, -1);
    check_image("skip_image");

    fill_random();
    load_stage();
    run_pass("abort", 2'd1, 1'b0, -1, 239, 600, 0, 0, 10, 276);

    fill_random();
    load_stage();
    run_pass("restart", 2'd3, 1'b1, 1241, 496, 0, 300, 0, 10, 565);
    check_image("restart_image");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
